// File: rtl/crc_result_serializer_if.sv
// crc_result_serializer_if
//   Bundles the load-side (result word in) and stream-side (bytes out) signals
//   of the CRC result serializer.
//   Ports of the bundle:
//     load_valid/load_ready      handshake for offering a finished CRC word
//     load_value                 CRC result word (MAX_BITS)
//     load_bytewidth             active byte count minus 1 (MAX_BYTE_WIDTH)
//     load_refout                reflect the word before emission
//     load_msb_first             byte order select
//     out_data/out_valid/out_ready/out_last  8-bit output stream
//     busy                       serializer is emitting a word
//   Modports:
//     slave  - the serializer itself
//     master - the environment driving words in and draining bytes out
interface crc_result_serializer_if #(
  parameter int MAX_BITS       = 32,
  parameter int MAX_BYTE_WIDTH = 2
);
  logic                      load_valid;
  logic                      load_ready;
  logic [MAX_BITS-1:0]       load_value;
  logic [MAX_BYTE_WIDTH-1:0] load_bytewidth;
  logic                      load_refout;
  logic                      load_msb_first;
  logic [7:0]                out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      busy;

  modport slave (
    input  load_valid, load_value, load_bytewidth, load_refout, load_msb_first, out_ready,
    output load_ready, out_data, out_valid, out_last, busy
  );

  modport master (
    output load_valid, load_value, load_bytewidth, load_refout, load_msb_first, out_ready,
    input  load_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/crc_result_serializer.sv
// crc_result_serializer
//   Accepts a finished CRC result word and streams it out one byte per accepted
//   beat on a valid/ready 8-bit port. Bits above the active byte width are masked
//   off at capture. Outputs are all registered; the first byte appears the cycle
//   after the word is accepted.
//   Ports:
//     clk    - single rising-edge clock
//     rst_n  - asynchronous active-low reset; discards any word in flight
//     bus    - crc_result_serializer_if.slave (load handshake, byte stream, busy)
//   Parameters: MAX_BITS (= 8*MAX_BYTES), MAX_BYTES, MAX_BYTE_WIDTH.
//   Optional feature macro: REFOUT_REFLECT_EN
//     defined   - load_refout=1 reflects the masked word over 8*(bytewidth+1) bits
//     undefined - load_refout is ignored, words are emitted unreflected
module crc_result_serializer #(
  parameter int MAX_BITS       = 32,
  parameter int MAX_BYTES      = 4,
  parameter int MAX_BYTE_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  crc_result_serializer_if.slave  bus
);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                    state_q, state_d;
  logic [MAX_BITS-1:0]       word_q, word_d;
  logic [MAX_BYTE_WIDTH-1:0] cnt_q, cnt_d;
  logic [MAX_BYTE_WIDTH-1:0] idx_q, idx_d;
  logic                      msb_first_q, msb_first_d;
  logic [7:0]                out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;

  logic [MAX_BITS-1:0]       masked_word;
  logic [MAX_BITS-1:0]       cap_word;
  logic [MAX_BYTE_WIDTH-1:0] first_idx;
  logic [MAX_BYTE_WIDTH-1:0] next_idx;

  // Zero every byte above the active byte count.
  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_mask
    assign masked_word[gi*8 +: 8] = (MAX_BYTE_WIDTH'(gi) <= bus.load_bytewidth)
                                    ? bus.load_value[gi*8 +: 8] : 8'h00;
  end

`ifdef REFOUT_REFLECT_EN
  logic [MAX_BITS-1:0]         rev_word;
  logic [MAX_BYTE_WIDTH+2:0]   refl_shift;

  for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_rev
    assign rev_word[gi] = masked_word[MAX_BITS-1-gi];
  end

  // Full-width reversal puts the active N bits at the top; shifting down by
  // MAX_BITS-N lands bit i at N-1-i and leaves bits >= N at zero.
  assign refl_shift = {MAX_BYTE_WIDTH'(MAX_BYTES-1) - bus.load_bytewidth, 3'b000};
  assign cap_word   = bus.load_refout ? (rev_word >> refl_shift) : masked_word;
`else
  logic unused_refout;
  assign unused_refout = bus.load_refout;
  assign cap_word      = masked_word;
`endif

  // msb-first walks the byte index down from bytewidth, lsb-first walks up from 0.
  assign first_idx = bus.load_msb_first ? bus.load_bytewidth : '0;
  assign next_idx  = msb_first_q ? (idx_q - MAX_BYTE_WIDTH'(1)) : (idx_q + MAX_BYTE_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    msb_first_d = msb_first_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          word_d      = cap_word;
          cnt_d       = bus.load_bytewidth;
          idx_d       = first_idx;
          msb_first_d = bus.load_msb_first;
          out_data_d  = cap_word[{first_idx, 3'b000} +: 8];
          out_valid_d = 1'b1;
          out_last_d  = (bus.load_bytewidth == '0);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (out_valid_q && bus.out_ready) begin
          if (cnt_q == '0) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'h00;
          end else begin
            cnt_d      = cnt_q - MAX_BYTE_WIDTH'(1);
            idx_d      = next_idx;
            out_data_d = word_q[{next_idx, 3'b000} +: 8];
            out_last_d = (cnt_q == MAX_BYTE_WIDTH'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      msb_first_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      msb_first_q <= msb_first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_crc_result_serializer.sv
// tb_crc_result_serializer
//   Directed bench for crc_result_serializer: reset state, both byte orders,
//   masking, optional reflection (REFOUT_REFLECT_EN), backpressure, async reset
//   mid-word and back-to-back words.
module tb_crc_result_serializer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   beat_count;

  crc_result_serializer_if #(.MAX_BITS(32), .MAX_BYTE_WIDTH(2)) bus_if ();

  crc_result_serializer #(.MAX_BITS(32), .MAX_BYTES(4), .MAX_BYTE_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single cycle; caller guarantees the serializer is idle.
  task automatic send_word(input logic [31:0] v, input logic [1:0] bw,
                           input logic rf, input logic msb);
    chk("load_ready_before_load", 32'(bus_if.load_ready), 32'd1);
    bus_if.load_value     = v;
    bus_if.load_bytewidth = bw;
    bus_if.load_refout    = rf;
    bus_if.load_msb_first = msb;
    bus_if.load_valid     = 1'b1;
    step();
    bus_if.load_valid     = 1'b0;
  endtask

  // Check the presented byte and let it transfer (out_ready must be high).
  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    chk({tag, "_data"},  32'(bus_if.out_data),  32'(d));
    chk({tag, "_last"},  32'(bus_if.out_last),  32'(l));
    chk({tag, "_ready"}, 32'(bus_if.load_ready), 32'd0);
    chk({tag, "_busy"},  32'(bus_if.busy),       32'd1);
    step();
    beat_count++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus_if.out_valid),  32'd0);
    chk({tag, "_ready"}, 32'(bus_if.load_ready), 32'd1);
    chk({tag, "_busy"},  32'(bus_if.busy),       32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    beat_count = 0;
    rst_n = 1'b0;
    bus_if.load_valid     = 1'b0;
    bus_if.load_value     = '0;
    bus_if.load_bytewidth = '0;
    bus_if.load_refout    = 1'b0;
    bus_if.load_msb_first = 1'b0;
    bus_if.out_ready      = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus_if.out_last),  32'd0);
    chk("rst_out_data",  32'(bus_if.out_data),  32'h00);
    chk("rst_busy",      32'(bus_if.busy),      32'd0);
    rst_n = 1'b1;
    step();
    check_idle("post_rst");
    bus_if.out_ready = 1'b1;

    // 1: msb-first full word
    send_word(32'h12345678, 2'd3, 1'b0, 1'b1);
    beat("t1_b0", 8'h12, 1'b0);
    beat("t1_b1", 8'h34, 1'b0);
    beat("t1_b2", 8'h56, 1'b0);
    beat("t1_b3", 8'h78, 1'b1);
    check_idle("t1_end");

    // 2: lsb-first full word
    send_word(32'h12345678, 2'd3, 1'b0, 1'b0);
    beat("t2_b0", 8'h78, 1'b0);
    beat("t2_b1", 8'h56, 1'b0);
    beat("t2_b2", 8'h34, 1'b0);
    beat("t2_b3", 8'h12, 1'b1);
    check_idle("t2_end");

    // 3: reflection over 16 bits, then masking to one byte
    send_word(32'h00000001, 2'd1, 1'b1, 1'b1);
`ifdef REFOUT_REFLECT_EN
    beat("t3_b0", 8'h80, 1'b0);
    beat("t3_b1", 8'h00, 1'b1);
`else
    beat("t3_b0", 8'h00, 1'b0);
    beat("t3_b1", 8'h01, 1'b1);
`endif
    check_idle("t3a_end");
    send_word(32'hFFFF00A5, 2'd0, 1'b1, 1'b1);
    beat("t3m_b0", 8'hA5, 1'b1);
    check_idle("t3m_end");
    send_word(32'hFFFF00A5, 2'd0, 1'b0, 1'b0);
    beat("t3n_b0", 8'hA5, 1'b1);
    check_idle("t3n_end");

    // 4: backpressure mid-word with a load attempt during SHIFT
    send_word(32'hA1B2C3D4, 2'd3, 1'b0, 1'b1);
    beat("t4_b0", 8'hA1, 1'b0);
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        bus_if.load_value     = 32'hDEADBEEF;
        bus_if.load_bytewidth = 2'd0;
        bus_if.load_msb_first = 1'b0;
        bus_if.load_valid     = 1'b1;
      end
      chk("t4_stall_valid", 32'(bus_if.out_valid),  32'd1);
      chk("t4_stall_data",  32'(bus_if.out_data),   32'hB2);
      chk("t4_stall_last",  32'(bus_if.out_last),   32'd0);
      chk("t4_stall_ready", 32'(bus_if.load_ready), 32'd0);
      step();
      bus_if.load_valid = 1'b0;
    end
    bus_if.out_ready = 1'b1;
    beat("t4_b1", 8'hB2, 1'b0);
    beat("t4_b2", 8'hC3, 1'b0);
    beat("t4_b3", 8'hD4, 1'b1);
    check_idle("t4_end");

    // 5: async reset after the 2nd beat
    send_word(32'h11223344, 2'd3, 1'b0, 1'b1);
    beat("t5_b0", 8'h11, 1'b0);
    beat("t5_b1", 8'h22, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_valid", 32'(bus_if.out_valid), 32'd0);
    chk("t5_rst_data",  32'(bus_if.out_data),  32'h00);
    chk("t5_rst_last",  32'(bus_if.out_last),  32'd0);
    chk("t5_rst_busy",  32'(bus_if.busy),      32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_idle("t5_post_rst");
    send_word(32'h55667788, 2'd3, 1'b0, 1'b0);
    beat("t5n_b0", 8'h88, 1'b0);
    beat("t5n_b1", 8'h77, 1'b0);
    beat("t5n_b2", 8'h66, 1'b0);
    beat("t5n_b3", 8'h55, 1'b1);
    check_idle("t5_end");

    // 6: load_valid held high across two words
    beat_count = 0;
    bus_if.load_value     = 32'h0000CAFE;
    bus_if.load_bytewidth = 2'd1;
    bus_if.load_refout    = 1'b0;
    bus_if.load_msb_first = 1'b1;
    bus_if.load_valid     = 1'b1;
    step();
    bus_if.load_value     = 32'hFF123456;
    bus_if.load_bytewidth = 2'd2;
    bus_if.load_msb_first = 1'b0;
    beat("t6a_b0", 8'hCA, 1'b0);
    beat("t6a_b1", 8'hFE, 1'b1);
    check_idle("t6_gap");
    step();
    bus_if.load_valid = 1'b0;
    beat("t6b_b0", 8'h56, 1'b0);
    beat("t6b_b1", 8'h34, 1'b0);
    beat("t6b_b2", 8'h12, 1'b1);
    check_idle("t6_end");
    chk("t6_total_beats", 32'(beat_count), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
